// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding decode over valid/ready,
// with stall hold, branch redirect/flush and an all-zero-word halt.
module fetch_unit #(
    parameter int N = 32,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst,
    output logic [N-1:0] pc_out,
    input  logic [N-1:0] instr,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic         if_valid,
    input  logic         if_ready,
    output logic [N-1:0] if_instr,
    output logic [N-1:0] if_pc,
    output logic         halted,
    output logic [N-1:0] fetch_count
);
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
    state_t state, state_n;
    logic [N-1:0] pc, pc_n, if_instr_n, if_pc_n;
    logic if_valid_n, halted_n, advance;
    assign pc_out = pc;
    assign advance = !if_valid || if_ready;
    always_comb begin
        state_n = state;
        pc_n = pc;
        if_valid_n = if_valid;
        if_instr_n = if_instr;
        if_pc_n = if_pc;
        halted_n = halted;
        if (state == IDLE) begin
            state_n = RUN;
        end else if (branch_taken) begin
            pc_n = {branch_target[N-1:2], 2'b00};
            if_valid_n = 1'b0;
            state_n = RUN;
            halted_n = 1'b0;
        end else if (state == RUN && advance) begin
            // a zero word stops fetch and is never handed to decode
            if (instr == '0) begin
                if_valid_n = 1'b0;
                state_n = HALT;
                halted_n = 1'b1;
            end else begin
                if_instr_n = instr;
                if_pc_n = pc;
                if_valid_n = 1'b1;
                pc_n = pc + N'(4);
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc <= RESET_PC;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc <= '0;
            halted <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            if_valid <= if_valid_n;
            if_instr <= if_instr_n;
            if_pc <= if_pc_n;
            halted <= halted_n;
            fetch_count <= fetch_count + {{(N-1){1'b0}}, if_valid && if_ready};
        end
    end
endmodule
